// File: rtl/alu_pkg.sv
// Shared opcodes, flag layout and helpers for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OP_W        = 6;
  localparam int unsigned ALU_FLAGS_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [ALU_FLAGS_W-1:0] alu_flags_t;

  // Assemble the flag nibble from individual bits using the shared index layout.
  function automatic alu_flags_t pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    alu_flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, op) -> result, N/Z/C/V flags and illegal-opcode flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_OP   = OP_W
) (
  input  logic [N_BITS-1:0]      a,
  input  logic [N_BITS-1:0]      b,
  input  logic [N_OP-1:0]        op,
  output logic [N_BITS-1:0]      result_c,
  output logic [ALU_FLAGS_W-1:0] flags_c,
  output logic                   op_err_c
);

  localparam int unsigned MSB = N_BITS - 1;
  localparam logic [N_BITS-1:0] SHIFT_LIM = N_BITS'(N_BITS);

  logic [N_BITS:0]          sum;
  logic [N_BITS:0]          diff;
  logic signed [N_BITS-1:0] a_s;
  logic signed [N_BITS-1:0] sra_r;
  logic [N_BITS-1:0]        srl_r;
  logic                     big_shift;
  logic                     carry;
  logic                     ovf;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign a_s       = $signed(a);
  // Kept in its own signed assignment so >>> stays arithmetic.
  assign sra_r     = a_s >>> b;
  assign srl_r     = a >> b;
  assign big_shift = (b >= SHIFT_LIM);

  always_comb begin
    result_c = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    op_err_c = 1'b0;
    case (op)
      N_OP'(OP_ADD): begin
        result_c = sum[N_BITS-1:0];
        carry    = sum[N_BITS];
        ovf      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      N_OP'(OP_SUB): begin
        result_c = diff[N_BITS-1:0];
        carry    = diff[N_BITS];
        ovf      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      N_OP'(OP_AND): result_c = a & b;
      N_OP'(OP_OR):  result_c = a | b;
      N_OP'(OP_XOR): result_c = a ^ b;
      N_OP'(OP_NOR): result_c = ~(a | b);
      N_OP'(OP_SRA): result_c = big_shift ? {N_BITS{a[MSB]}} : sra_r;
      N_OP'(OP_SRL): result_c = big_shift ? '0 : srl_r;
      default:       op_err_c = 1'b1;
    endcase
    flags_c = pack_flags(result_c[MSB], (result_c == '0), carry, ovf);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides, one beat per cycle.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_OP   = OP_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N_BITS-1:0]      i_A,
  input  logic [N_BITS-1:0]      i_B,
  input  logic [N_OP-1:0]        i_OP,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [N_BITS-1:0]      o_result,
  output logic [ALU_FLAGS_W-1:0] o_flags,
  output logic                   o_op_err
);

  logic                   s1_valid;
  logic [N_BITS-1:0]      s1_a;
  logic [N_BITS-1:0]      s1_b;
  logic [N_OP-1:0]        s1_op;
  logic                   s1_adv;
  logic [N_BITS-1:0]      core_result_c;
  logic [ALU_FLAGS_W-1:0] core_flags_c;
  logic                   core_err_c;

  // Readiness depends only on registered state and the consumer, never on i_valid.
  assign s1_adv  = !o_valid || i_ready;
  assign o_ready = !s1_valid || s1_adv;

  // Stage 1 valid: refilled (or emptied) whenever it can accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
    end
  end

  // Stage 1 operands only need loading on a transfer; valid qualifies them.
  always_ff @(posedge clock) begin
    if (i_valid && o_ready) begin
      s1_a  <= i_A;
      s1_b  <= i_B;
      s1_op <= i_OP;
    end
  end

  alu_core #(
    .N_BITS (N_BITS),
    .N_OP   (N_OP)
  ) u_core (
    .a        (s1_a),
    .b        (s1_b),
    .op       (s1_op),
    .result_c (core_result_c),
    .flags_c  (core_flags_c),
    .op_err_c (core_err_c)
  );

  // Stage 2 is the output register; payload holds when stalled or empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
      o_op_err <= 1'b0;
    end else if (s1_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= core_result_c;
        o_flags  <= core_flags_c;
        o_op_err <= core_err_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe at N_BITS=8.
module tb_alu_pipe;

  localparam int unsigned NB = 8;
  localparam int unsigned NO = 6;

  localparam logic [5:0] T_ADD = 6'b100000;
  localparam logic [5:0] T_SUB = 6'b100010;
  localparam logic [5:0] T_AND = 6'b100100;
  localparam logic [5:0] T_OR  = 6'b100101;
  localparam logic [5:0] T_XOR = 6'b100110;
  localparam logic [5:0] T_NOR = 6'b100111;
  localparam logic [5:0] T_SRA = 6'b000011;
  localparam logic [5:0] T_SRL = 6'b000010;
  localparam logic [5:0] T_BAD = 6'b111111;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_valid;
  logic          o_ready;
  logic [NB-1:0] i_A;
  logic [NB-1:0] i_B;
  logic [NO-1:0] i_OP;
  logic          o_valid;
  logic          i_ready;
  logic [NB-1:0] o_result;
  logic [3:0]    o_flags;
  logic          o_op_err;

  always #5 clock = ~clock;

  alu_pipe #(.N_BITS(NB), .N_OP(NO)) dut (
    .clock    (clock),
    .reset    (reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_A      (i_A),
    .i_B      (i_B),
    .i_OP     (i_OP),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flags  (o_flags),
    .o_op_err (o_op_err)
  );

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   out_count = 0;
  bit   in_xfer;
  bit   out_xfer;
  bit   last_o_ready;

  function automatic exp_t mk(input logic [7:0] res, input logic [3:0] fl, input logic err);
    exp_t e;
    e.res = res;
    e.fl  = fl;
    e.err = err;
    return e;
  endfunction

  // Reference model in integer arithmetic; flags are {N,Z,C,V}.
  function automatic exp_t model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    bit c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0;
    c = 0;
    v = 0;
    e.err = 1'b0;
    case (op)
      T_ADD: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      T_SUB: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      T_AND: r = ua & ub;
      T_OR:  r = ua | ub;
      T_XOR: r = ua ^ ub;
      T_NOR: r = ~(ua | ub);
      T_SRA: r = (ub >= 8) ? (a[7] ? 255 : 0) : (sa >>> ub);
      T_SRL: r = (ub >= 8) ? 0 : (ua >> ub);
      default: e.err = 1'b1;
    endcase
    e.res = r[7:0];
    e.fl  = {e.res[7], (e.res == 8'h00), c, v};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: score the handshakes about to happen, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    last_o_ready = o_ready;
    in_xfer  = !reset && i_valid && o_ready;
    out_xfer = !reset && o_valid && i_ready;
    if (out_xfer) begin
      out_count++;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL extra_beat: observed beat %0h with empty scoreboard, expected none", o_result);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("result", 32'(o_result), 32'(e.res));
        check("flags", 32'(o_flags), 32'(e.fl));
        check("op_err", 32'(o_op_err), 32'(e.err));
      end
    end
    if (in_xfer) q.push_back(cur);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    i_valid = 1'b1;
    i_OP    = op;
    i_A     = a;
    i_B     = b;
    cur     = e;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_OP    = 6'($urandom);
    i_A     = 8'($urandom);
    i_B     = 8'($urandom);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (q.size() != 0 || o_valid); i++) tick();
    check({"drain_", tag}, 32'(q.size()), 32'd0);
  endtask

  logic [5:0] b_op [8];
  logic [7:0] b_a  [8];
  logic [7:0] b_b  [8];

  initial begin
    int   idx;
    int   out_start;
    bit   stalled_prev;
    bit   saw_block;
    logic [12:0] held;

    b_op = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR, T_SRA, T_SRL};
    b_a  = '{8'hF0, 8'h80, 8'hCC, 8'h0C, 8'hFF, 8'h00, 8'h7F, 8'h81};
    b_b  = '{8'h20, 8'h01, 8'hAA, 8'h30, 8'h0F, 8'h00, 8'h03, 8'h07};

    reset   = 1'b1;
    i_ready = 1'b1;
    i_valid = 1'b0;
    i_A     = '0;
    i_B     = '0;
    i_OP    = '0;
    cur     = mk(8'h00, 4'h0, 1'b0);
    repeat (3) @(negedge clock);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    check("rst_o_result", 32'(o_result), 32'd0);
    check("rst_o_flags", 32'(o_flags), 32'd0);
    check("rst_o_op_err", 32'(o_op_err), 32'd0);
    reset = 1'b0;

    // ADD overflow into the sign bit, with latency probes
    send(T_ADD, 8'h7F, 8'h01, mk(8'h80, 4'b1001, 1'b0));
    tick();
    idle();
    check("lat1_o_valid", 32'(o_valid), 32'd0);
    tick();
    check("lat2_o_valid", 32'(o_valid), 32'd1);
    drain("add", 10);

    // SUB borrow, then SUB to zero
    send(T_SUB, 8'h05, 8'h07, mk(8'hFE, 4'b1010, 1'b0));
    tick();
    send(T_SUB, 8'h33, 8'h33, mk(8'h00, 4'b0100, 1'b0));
    tick();
    idle();
    drain("sub", 10);

    // Shifts including amounts beyond the width
    send(T_SRA, 8'h90, 8'd2, mk(8'hE4, 4'b1000, 1'b0)); tick();
    send(T_SRL, 8'h90, 8'd2, mk(8'h24, 4'b0000, 1'b0)); tick();
    send(T_SRA, 8'h90, 8'd9, mk(8'hFF, 4'b1000, 1'b0)); tick();
    send(T_SRL, 8'h90, 8'd9, mk(8'h00, 4'b0100, 1'b0)); tick();
    idle();
    drain("shift", 10);

    // Unknown opcode, then a valid op that must clear the error bit
    send(T_BAD, 8'h12, 8'h34, mk(8'h00, 4'b0100, 1'b1)); tick();
    send(T_AND, 8'h0F, 8'h3C, mk(8'h0C, 4'b0000, 1'b0)); tick();
    idle();
    drain("badop", 10);

    // Back-to-back beats with the consumer stalled for cycles 3..6
    idx          = 0;
    out_start    = out_count;
    stalled_prev = 1'b0;
    saw_block    = 1'b0;
    held         = '0;
    for (int c = 0; c < 40; c++) begin
      i_ready = !(c >= 3 && c <= 6);
      if (idx < 8) send(b_op[idx], b_a[idx], b_b[idx], model(b_op[idx], b_a[idx], b_b[idx]));
      else idle();
      if (stalled_prev && o_valid) check("stall_hold", 32'({o_result, o_flags, o_op_err}), 32'(held));
      stalled_prev = o_valid && !i_ready;
      held         = {o_result, o_flags, o_op_err};
      tick();
      if (!last_o_ready) saw_block = 1'b1;
      if (in_xfer) idx++;
      if (idx == 8 && q.size() == 0 && !o_valid) break;
    end
    idle();
    i_ready = 1'b1;
    check("b2b_sent", 32'(idx), 32'd8);
    check("b2b_o_ready_dropped", 32'(saw_block), 32'd1);
    check("b2b_out_count", 32'(out_count - out_start), 32'd8);
    drain("b2b", 10);

    // Reset with both stages full under backpressure
    i_ready = 1'b0;
    send(T_ADD, 8'h01, 8'h01, mk(8'h02, 4'b0000, 1'b0)); tick();
    send(T_SUB, 8'h10, 8'h01, mk(8'h0F, 4'b0000, 1'b0)); tick();
    idle();
    #1;
    check("full_o_valid", 32'(o_valid), 32'd1);
    check("full_o_ready", 32'(o_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("rst2_o_valid", 32'(o_valid), 32'd0);
    check("rst2_o_ready", 32'(o_ready), 32'd1);
    check("rst2_o_result", 32'(o_result), 32'd0);
    check("rst2_o_flags", 32'(o_flags), 32'd0);
    check("rst2_o_op_err", 32'(o_op_err), 32'd0);
    q.delete();
    reset   = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_stale", 32'(o_valid), 32'd0);
    end

    // Pipeline still works after the mid-stream reset
    send(T_ADD, 8'hF0, 8'h20, model(T_ADD, 8'hF0, 8'h20)); tick();
    idle();
    drain("post_rst", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
